uart_rx_bit_timer: RTL and testbench

// - Oversampling timing engine for the UART receiver; successor to the fixed 8/16x edge/bit counter.
// - Generates edge and bit timing for any prescale from 4 to 2^PRESCALE_W-1.
// - Majority-votes three mid-bit samples and reports frame completion with optional parity bit.
// - Sits between the RX synchroniser and the RX FSM / deserialiser / parity / stop checkers.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_majority_sampler.sv | 60 ++++++
 rtl/uart_rx_bit_timer.sv | 127 ++++++++++++
 tb/tb_uart_rx_bit_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receive timing path.
// Holds prescale limits, frame-position helpers and the mid-bit sample slot encoding.
package uart_rx_pkg;

    localparam int unsigned MIN_PRESCALE = 4;
    localparam int unsigned RST_PRESCALE = 16;
    localparam int unsigned START_IDX    = 0;

    typedef enum logic [1:0] {
        SlotLo  = 2'd0,
        SlotMid = 2'd1,
        SlotHi  = 2'd2
    } sample_slot_e;

    // Stop bit position: start bit, data bits, optional parity, then stop.
    function automatic int unsigned stop_idx(input int unsigned data_width, input logic par_en);
        return data_width + (par_en ? 32'd2 : 32'd1);
    endfunction

endpackage

// File: rtl/uart_majority_sampler.sv
// Captures three mid-bit samples of the serial line and registers their majority vote.
// The third sample is voted straight from rx_in so the result lands one clock after it.
module uart_majority_sampler
    import uart_rx_pkg::*;
#(
    parameter int unsigned BIT_CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 strobe,
    input  logic [1:0]           slot,
    input  logic                 rx_in,
    input  logic [BIT_CNT_W-1:0] bit_idx,
    output logic                 sample_valid,
    output logic                 sampled_bit,
    output logic [BIT_CNT_W-1:0] sample_idx
);

    logic                 s0_q;
    logic                 s1_q;
    logic                 valid_q;
    logic                 bit_q;
    logic [BIT_CNT_W-1:0] idx_q;
    logic                 take_lo;
    logic                 take_mid;
    logic                 take_hi;
    logic                 vote;

    assign take_lo  = strobe && (slot == SlotLo);
    assign take_mid = strobe && (slot == SlotMid);
    assign take_hi  = strobe && (slot == SlotHi);
    assign vote     = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            valid_q <= take_hi;
            if (take_lo) begin
                s0_q <= rx_in;
            end
            if (take_mid) begin
                s1_q <= rx_in;
            end
            if (take_hi) begin
                bit_q <= vote;
                idx_q <= bit_idx;
            end
        end
    end

    assign sample_valid = valid_q;
    assign sampled_bit  = bit_q;
    assign sample_idx   = idx_q;

endmodule

// File: rtl/uart_rx_bit_timer.sv
// Oversampling edge/bit timer for the UART receiver with configurable prescale and parity.
// Captures config on the rising edge of enable and feeds the majority sampler at mid-bit.
module uart_rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  rx_in,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_idx,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  sample_valid,
    output logic                  sampled_bit,
    output logic [BIT_CNT_W-1:0]  sample_idx
);

    localparam logic [PRESCALE_W-1:0] MinPresc  = PRESCALE_W'(MIN_PRESCALE);
    localparam logic [PRESCALE_W-1:0] RstPresc  = PRESCALE_W'(RST_PRESCALE);
    localparam logic [PRESCALE_W-1:0] OneEdge   = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  OneBit    = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  StartIdx  = BIT_CNT_W'(START_IDX);
    localparam logic [BIT_CNT_W-1:0]  StopNoPar = BIT_CNT_W'(stop_idx(DATA_WIDTH, 1'b0));
    localparam logic [BIT_CNT_W-1:0]  StopPar   = BIT_CNT_W'(stop_idx(DATA_WIDTH, 1'b1));

    logic                  en_q;
    logic                  par_en_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] edge_q;
    logic [PRESCALE_W-1:0] edge_d;
    logic [BIT_CNT_W-1:0]  bit_q;
    logic [BIT_CNT_W-1:0]  bit_d;

    logic [PRESCALE_W-1:0] last_edge;
    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] mid_lo;
    logic [PRESCALE_W-1:0] mid_hi;
    logic [BIT_CNT_W-1:0]  last_bit;
    logic                  edge_wrap;
    logic                  frame_wrap;
    logic                  strobe;
    sample_slot_e          slot;

    assign last_edge = prescale_q - OneEdge;
    assign mid       = prescale_q >> 1;
    assign mid_lo    = mid - OneEdge;
    assign mid_hi    = mid + OneEdge;
    assign last_bit  = par_en_q ? StopPar : StopNoPar;

    // Counters sit at zero whenever enable is low, so the capture cycle is always edge 0
    // and the stale prescale_q cannot produce a spurious wrap or strobe in that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q       <= 1'b0;
            par_en_q   <= 1'b0;
            prescale_q <= RstPresc;
            edge_q     <= '0;
            bit_q      <= '0;
        end else begin
            en_q   <= enable;
            edge_q <= edge_d;
            bit_q  <= bit_d;
            if (enable && !en_q) begin
                prescale_q <= (prescale < MinPresc) ? MinPresc : prescale;
                par_en_q   <= par_en;
            end
        end
    end

    always_comb begin
        edge_wrap  = enable && (edge_q == last_edge);
        frame_wrap = edge_wrap && (bit_q == last_bit);
        edge_d     = edge_q + OneEdge;
        bit_d      = bit_q;
        if (!enable) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (edge_wrap) begin
            edge_d = '0;
            bit_d  = frame_wrap ? StartIdx : bit_q + OneBit;
        end
    end

    always_comb begin
        strobe = 1'b0;
        slot   = SlotLo;
        if (enable) begin
            if (edge_q == mid_lo) begin
                strobe = 1'b1;
                slot   = SlotLo;
            end else if (edge_q == mid) begin
                strobe = 1'b1;
                slot   = SlotMid;
            end else if (edge_q == mid_hi) begin
                strobe = 1'b1;
                slot   = SlotHi;
            end
        end
    end

    uart_majority_sampler #(
        .BIT_CNT_W (BIT_CNT_W)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .strobe       (strobe),
        .slot         (slot),
        .rx_in        (rx_in),
        .bit_idx      (bit_q),
        .sample_valid (sample_valid),
        .sampled_bit  (sampled_bit),
        .sample_idx   (sample_idx)
    );

    assign edge_cnt   = edge_q;
    assign bit_idx    = bit_q;
    assign bit_done   = edge_wrap;
    assign frame_done = frame_wrap;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed bench for uart_rx_bit_timer: table of frame vectors plus enable-drop and
// mid-frame reset sequences, with edge/bit positions predicted from a cycle counter.
module tb_uart_rx_bit_timer;

    typedef struct {
        logic [5:0]  presc;
        logic        par;
        logic [63:0] mask;      // edges of bit tbit where rx_in is driven low
        int          tbit;
        logic        exp_bit;
        int          exp_frame;
        int          vedge;     // edge_cnt when the sample for tbit is reported
        int          nfr;
        bit          chg;       // change config inputs mid-frame
    } vec_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [5:0] prescale;
    logic       par_en;
    logic       rx_in;
    logic [5:0] edge_cnt;
    logic [4:0] bit_idx;
    logic       bit_done;
    logic       frame_done;
    logic       sample_valid;
    logic       sampled_bit;
    logic [4:0] sample_idx;

    int total;
    int bad;
    int r_frames;
    int r_first;
    int r_err;
    int r_seen;
    int r_bit;
    int r_vedge;

    vec_t vecs[10];

    uart_rx_bit_timer #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6),
        .BIT_CNT_W  (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .prescale     (prescale),
        .par_en       (par_en),
        .rx_in        (rx_in),
        .edge_cnt     (edge_cnt),
        .bit_idx      (bit_idx),
        .bit_done     (bit_done),
        .frame_done   (frame_done),
        .sample_valid (sample_valid),
        .sampled_bit  (sampled_bit),
        .sample_idx   (sample_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Runs enable-high cycles from a rising edge of enable; cycle k is predicted to be
    // edge k%p of bit (k/p)%nb.
    task automatic run(input vec_t v, input int max_k, input int stop_frames);
        int p;
        int nb;
        int e;
        int b;
        p        = (v.presc < 6'd4) ? 4 : int'(v.presc);
        nb       = 10 + int'(v.par);
        r_frames = 0;
        r_first  = -1;
        r_err    = 0;
        r_seen   = 0;
        r_bit    = 0;
        r_vedge  = -1;
        prescale = v.presc;
        par_en   = v.par;
        for (int k = 0; k < max_k; k++) begin
            @(posedge clk);
            #1;
            enable = 1'b1;
            if (v.chg && k == 5) begin
                prescale = 6'd8;
                par_en   = ~v.par;
            end
            e     = k % p;
            b     = (k / p) % nb;
            rx_in = (b == v.tbit && v.mask[e]) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (edge_cnt != e || bit_idx != b || bit_done != (e == p - 1) ||
                frame_done != (e == p - 1 && b == nb - 1)) begin
                r_err++;
            end
            if (sample_valid && sample_idx == v.tbit && r_seen == 0) begin
                r_seen  = 1;
                r_bit   = int'(sampled_bit);
                r_vedge = int'(edge_cnt);
            end
            if (frame_done) begin
                r_frames++;
                if (r_first < 0) r_first = k + 1;
                if (r_frames == stop_frames) break;
            end
        end
    endtask

    initial begin
        int p;
        int nb;
        vec_t v;
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        enable   = 1'b0;
        prescale = 6'd0;
        par_en   = 1'b0;
        rx_in    = 1'b1;

        vecs[0] = '{6'd16, 1'b0, 64'h0,           3, 1'b1, 160, 10, 2, 1'b1};
        vecs[1] = '{6'd8,  1'b0, 64'h10,          2, 1'b1, 80,  6,  1, 1'b0};
        vecs[2] = '{6'd8,  1'b0, 64'h28,          2, 1'b0, 80,  6,  1, 1'b0};
        vecs[3] = '{6'd8,  1'b0, 64'h44,          4, 1'b1, 80,  6,  1, 1'b0};
        vecs[4] = '{6'd7,  1'b1, 64'h0C,          5, 1'b0, 77,  5,  1, 1'b0};
        vecs[5] = '{6'd7,  1'b1, 64'h22,          5, 1'b1, 77,  5,  1, 1'b0};
        vecs[6] = '{6'd2,  1'b0, 64'h0E,          0, 1'b0, 40,  0,  1, 1'b0};
        vecs[7] = '{6'd0,  1'b0, 64'h04,          4, 1'b1, 40,  0,  1, 1'b0};
        vecs[8] = '{6'd5,  1'b0, 64'h0A,          7, 1'b0, 50,  4,  1, 1'b0};
        vecs[9] = '{6'd63, 1'b1, 64'h1_C000_0000, 9, 1'b0, 693, 33, 1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset edge_cnt", edge_cnt, 0);
        check("reset bit_idx", bit_idx, 0);
        check("reset pulses", {bit_done, frame_done, sample_valid, sampled_bit}, 0);
        check("reset sample_idx", sample_idx, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            p  = (vecs[i].presc < 6'd4) ? 4 : int'(vecs[i].presc);
            nb = 10 + int'(vecs[i].par);
            run(vecs[i], vecs[i].nfr * nb * p + 8, vecs[i].nfr);
            check($sformatf("v%0d frame_len", i), r_first, vecs[i].exp_frame);
            check($sformatf("v%0d frames", i), r_frames, vecs[i].nfr);
            check($sformatf("v%0d seq_errors", i), r_err, 0);
            check($sformatf("v%0d sample_seen", i), r_seen, 1);
            check($sformatf("v%0d sampled_bit", i), r_bit, vecs[i].exp_bit);
            check($sformatf("v%0d valid_edge", i), r_vedge, vecs[i].vedge);
            @(posedge clk);
            #1;
            enable = 1'b0;
            rx_in  = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d drop pulses", i), {bit_done, frame_done}, 0);
            check($sformatf("v%0d pending valid", i), sample_valid, (p == 4));
            if (p == 4) check($sformatf("v%0d pending idx", i), sample_idx, nb - 1);
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("v%0d idle counters", i), {edge_cnt, bit_idx}, 0);
        end

        // Enable dropped at bit 5 edge 2, then a clean restart.
        v = '{6'd8, 1'b0, 64'h0, 31, 1'b1, 80, 6, 1, 1'b0};
        run(v, 43, 1);
        check("drop pre seq_errors", r_err, 0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(negedge clk);
        check("drop cycle pulses", {bit_done, frame_done}, 0);
        check("drop cycle edge held", edge_cnt, 3);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("drop cleared", {edge_cnt, bit_idx}, 0);
        run(vecs[1], 88, 1);
        check("drop restart frame_len", r_first, 80);
        check("drop restart seq_errors", r_err, 0);
        check("drop restart sampled_bit", r_bit, 1);
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Reset pulsed mid-frame at bit 5.
        run(v, 43, 1);
        rst    = 1'b0;
        enable = 1'b0;
        #1;
        check("rst immediate counters", {edge_cnt, bit_idx}, 0);
        check("rst immediate pulses", {bit_done, frame_done, sample_valid}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst release pulses", {bit_done, frame_done, sample_valid}, 0);
        run(vecs[2], 88, 1);
        check("rst restart frame_len", r_first, 80);
        check("rst restart seq_errors", r_err, 0);
        check("rst restart sampled_bit", r_bit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
